rv32_instr_enc: RTL and testbench
=================================

RV32_INSTR_ENC -- requirements
Module: rv32_instr_enc

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  field bundle valid; in_ready  out  1  encoder can accept.
REQ-004 SHALL have: in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSRI, 7=illegal.
REQ-005 SHALL have: in_opcode in 7; in_rd in 5; in_rs1 in 5; in_rs2 in 5; in_funct3 in 3; in_funct7 in 7; in_imm in 32 (`XPR_LEN, signed byte offset or value).
REQ-006 SHALL have: out_valid  out  1; out_ready  in  1; out_instr  out  32  packed instruction; out_err  out  1  encoding error tag for out_instr.
REQ-007 SHALL have: enc_count  out  16  number of instructions delivered (out_valid & out_ready), wraps 0xFFFF->0.

Function
REQ-008 SHALL pack R as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-009 SHALL pack I as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-010 SHALL pack S as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-011 SHALL pack B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-012 SHALL pack U as {imm[31:12], rd, opcode}.
REQ-013 SHALL pack J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-014 SHALL pack CSRI as {funct7, rs2, imm[4:0], funct3, rd, opcode} ({funct7,rs2} = 12-bit CSR address).
REQ-015 SHALL, for in_fmt=7, emit out_instr=0x00000013 with out_err=1.
REQ-016 SHALL buffer encoded results in a 2-entry FIFO; a push occurs when in_valid & in_ready at a rising edge.
REQ-017 SHALL drive in_ready = (occupancy < 2), combinationally from registered occupancy only (no dependence on out_ready).
REQ-018 SHALL have latency 1: bundle accepted at edge N into an empty FIFO appears on out_valid/out_instr after edge N.
REQ-019 SHALL drive out_valid = (occupancy > 0); out_instr/out_err SHALL be the head entry and SHALL hold stable while out_valid & !out_ready.
REQ-020 SHALL pop on out_valid & out_ready; simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with the new entry behind none (head replaced in order).
REQ-021 SHALL deliver entries strictly in acceptance order; pushes with in_ready=0 SHALL be ignored (no drop, no overwrite).
REQ-022 SHALL increment enc_count once per pop, including err-tagged entries.

Reset
REQ-023 SHALL on rst=1 at an edge set occupancy=0, out_valid=0, out_instr=0, out_err=0, enc_count=0, in_ready=1 after that edge.
REQ-024 SHALL discard buffered entries on reset mid-operation; push/pop in the reset cycle SHALL be ignored.

Configuration
REQ-025 SHALL honour macro RV32_ENC_RANGE_CHECK_EN.
REQ-026 With RV32_ENC_RANGE_CHECK_EN defined, out_err SHALL also be set when: I/S imm outside -2048..2047; B imm[0]!=0 or outside -4096..4094; J imm[0]!=0 or outside -1048576..1048574; U imm[11:0]!=0; CSRI imm outside 0..31; out_instr still packed per REQ-009..014 (truncated bits).
REQ-027 Without the macro, out_err SHALL be set only for in_fmt=7; out-of-range bits silently truncated; no check logic synthesized.

Verification
REQ-028 ADDI: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, out_err=0, out_valid one cycle after accept.
REQ-029 BEQ/LUI: fmt=3, op=0x63, regs 0, imm=8 -> 0x00000463; fmt=4, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-030 JAL: fmt=5, op=0x6F, rd=1, imm=0x800 -> 0x001000EF; decoding it back SHALL yield imm 0x00000800.
REQ-031 Backpressure: out_ready=0, offer 3 bundles -> in_ready=0 after 2 accepts, third held; raise out_ready -> all 3 in order, enc_count=3.
REQ-032 Range: fmt=3, imm=3 -> out_err=1 with RV32_ENC_RANGE_CHECK_EN, 0 without; fmt=7 -> 0x00000013, out_err=1 both builds.
REQ-033 Reset with 2 entries buffered -> out_valid=0, enc_count=0, in_ready=1 next cycle, flushed entries never appear.

Source files
------------

// File: rtl/rv32_instr_enc_if.sv
// Field-bundle in / packed-instruction out handshake bus for rv32_instr_enc.
// The encoder connects through the slave modport; the producer/consumer uses master.
interface rv32_instr_enc_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_instr, out_err
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_instr, out_err
   );
endinterface

// File: rtl/rv32_instr_enc.sv
// RV32 instruction encoder: packs field bundles into 32-bit words behind a 2-entry FIFO.
// Optional immediate range checking is enabled with macro RV32_ENC_RANGE_CHECK_EN.
module rv32_instr_enc (
   input  logic              clk,
   input  logic              rst,
   rv32_instr_enc_if.slave   bus,
   output logic [15:0]       enc_count
);
   localparam int XPR_LEN = 32;

   logic [XPR_LEN-1:0] w_imm;
   logic [31:0]        w_instr;
   logic               w_fmt_err;
   logic               w_range_err;
   logic               w_push;
   logic               w_pop;

   logic [31:0]        r_instr [2];
   logic               r_err   [2];
   logic               r_rd_ptr;
   logic               r_wr_ptr;
   logic [1:0]         r_occ;
   logic [15:0]        r_count;

   assign w_imm = bus.in_imm;

   always_comb begin
      w_instr   = 32'h0000_0013;
      w_fmt_err = 1'b0;
      case (bus.in_fmt)
         3'd0: w_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
         3'd1: w_instr = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
         3'd2: w_instr = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
         3'd3: w_instr = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          w_imm[4:1], w_imm[11], bus.in_opcode};
         3'd4: w_instr = {w_imm[31:12], bus.in_rd, bus.in_opcode};
         3'd5: w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
         3'd6: w_instr = {bus.in_funct7, bus.in_rs2, w_imm[4:0], bus.in_funct3, bus.in_rd, bus.in_opcode};
         default: begin
            w_instr   = 32'h0000_0013;
            w_fmt_err = 1'b1;
         end
      endcase
   end

`ifdef RV32_ENC_RANGE_CHECK_EN
   // Signed-range checks reduce to "all bits above the field equal the sign bit".
   always_comb begin
      w_range_err = 1'b0;
      case (bus.in_fmt)
         3'd1, 3'd2: w_range_err = !((&w_imm[31:11]) || !(|w_imm[31:11]));
         3'd3:       w_range_err = w_imm[0] || !((&w_imm[31:12]) || !(|w_imm[31:12]));
         3'd4:       w_range_err = |w_imm[11:0];
         3'd5:       w_range_err = w_imm[0] || !((&w_imm[31:20]) || !(|w_imm[31:20]));
         3'd6:       w_range_err = |w_imm[31:5];
         default:    w_range_err = 1'b0;
      endcase
   end
`else
   assign w_range_err = 1'b0;
`endif

   assign bus.in_ready  = (r_occ != 2'd2);
   assign bus.out_valid = (r_occ != 2'd0);
   assign bus.out_instr = r_instr[r_rd_ptr];
   assign bus.out_err   = r_err[r_rd_ptr];
   assign enc_count     = r_count;

   assign w_push = bus.in_valid & bus.in_ready;
   assign w_pop  = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr[0] <= '0;
         r_instr[1] <= '0;
         r_err[0]   <= 1'b0;
         r_err[1]   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_occ      <= 2'd0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_instr[r_wr_ptr] <= w_instr;
            r_err[r_wr_ptr]   <= w_fmt_err | w_range_err;
            r_wr_ptr          <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
            r_count  <= r_count + 16'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end
endmodule

// File: tb/tb_rv32_instr_enc.sv
// Directed-vector bench for rv32_instr_enc with hand-computed encodings.
module tb_rv32_instr_enc;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] enc_count;
   int          n_vec = 0;
   int          n_err = 0;
   int          exp_cnt;
   logic [31:0] w_dimm;

   rv32_instr_enc_if bus ();

   rv32_instr_enc dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .enc_count (enc_count)
   );

   always #5 clk = ~clk;

`ifdef RV32_ENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      bus.in_valid  = 1'b1;
      bus.in_fmt    = fmt;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
   endtask

   // One bundle through an empty FIFO with out_ready high: visible one edge after accept.
   task automatic vec(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_instr"}, bus.out_instr, exp_instr);
      chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
      @(posedge clk);
      exp_cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      bus.in_valid = 1'b0;
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_count", 32'(enc_count), 32'd0);

      vec("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
      vec("beq",  3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0000_0463, 1'b0);
      vec("lui",  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      vec("jal",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
      vec("add",  3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
      vec("sw",   3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
      vec("csri", 3'd6, 7'h73, 5'd1, 5'd0, 5'd0, 3'd5, 7'h18, 32'd5, 32'h3002_D0F3, 1'b0);
      vec("ill",  3'd7, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1);
      vec("b_odd", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, RC);
      vec("i_2048", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0013, RC);
      vec("i_m2048", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0);

      // JAL word decoded back to its byte offset
      w_dimm = 32'h0010_00EF;
      w_dimm = {{11{w_dimm[31]}}, w_dimm[31], w_dimm[19:12], w_dimm[20], w_dimm[30:21], 1'b0};
      chk("jal_decode", w_dimm, 32'h0000_0800);

      @(negedge clk);
      chk("count_after_dir", 32'(enc_count), 32'(exp_cnt));

      // Backpressure: two accepts fill the FIFO, the third bundle is held off
      do_reset();
      bus.out_ready = 1'b0;
      drive(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      drive(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
      drive(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_held_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_head_stable", bus.out_instr, 32'h0000_00B7);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_second", bus.out_instr, 32'h0000_0137);
      chk("bp_ready_again", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_third", bus.out_instr, 32'h0000_01B7);
      chk("bp_third_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("bp_drained", 32'(bus.out_valid), 32'd0);
      chk("bp_count", 32'(enc_count), 32'd3);

      // Reset with two entries buffered; push/pop offered in the reset cycle
      bus.out_ready = 1'b0;
      drive(3'd4, 7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1111_1000);
      @(posedge clk);
      @(negedge clk);
      drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h2222_2000);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_count", 32'(enc_count), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_instr", bus.out_instr, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("flushed_stay_gone", 32'(bus.out_valid), 32'd0);
      exp_cnt = 0;
      vec("post_rst", 3'd4, 7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3333_3000, 32'h3333_3337, 1'b0);
      @(negedge clk);
      chk("post_rst_count", 32'(enc_count), 32'(exp_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
